scan_mux_reg: RTL and testbench



---
 rtl/mux_pkg.sv | 15 +
 rtl/scan_mux_reg_if.sv | 33 +++
 rtl/rr_pick.sv | 35 +++
 rtl/scan_mux_reg.sv | 128 ++++++++++++
 tb/tb_scan_mux_reg.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the registered scan/direct channel multiplexer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: selection-mode encodings and the output-register state type.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/scan_mux_reg_if.sv
// Bus bundle between the producer channels, the mux and the downstream consumer.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the consumer; in_ready back to the producers.
// Ports: mode/address select, flattened in_data, per-channel in_valid/in_ready,
//        out_data/out_sel/out_valid/out_ready towards the consumer, addr_err pulse.
// master = producers + consumer side, slave = the mux itself.
interface scan_mux_reg_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                      mode;
  logic [SEL_W-1:0]          address;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_valid;
  logic                      out_ready;
  logic                      addr_err;

  modport master (
    output mode, address, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid, addr_err
  );

  modport slave (
    input  mode, address, in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid, addr_err
  );
endinterface

// File: rtl/rr_pick.sv
// Finds the first valid channel at or after ptr, wrapping modulo CHANNELS.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
// Ports: valid (per channel), ptr (search start) -> found, idx (winning channel).
module rr_pick #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] valid,
  input  logic [SEL_W-1:0]    ptr,
  output logic                found,
  output logic [SEL_W-1:0]    idx
);

  localparam logic [SEL_W:0] CH_L = (SEL_W+1)'(CHANNELS);

  // Walk offsets from the farthest to the nearest so the nearest valid
  // channel (smallest offset from ptr) is the last one written and wins.
  // ptr is always < CHANNELS, so a single subtraction folds the wrap.
  always_comb begin
    logic [SEL_W:0] c;
    found = 1'b0;
    idx   = '0;
    c     = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      c = {1'b0, ptr} + (SEL_W+1)'(i);
      if (c >= CH_L) c = c - CH_L;
      if (valid[c[SEL_W-1:0]]) begin
        found = 1'b1;
        idx   = c[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/scan_mux_reg.sv
// N-channel W-bit registered mux with one-entry output buffer; direct or round-robin scan select.
// Latency: 1 cycle from in_data/in_valid to out_data/out_valid; full throughput when out_ready held.
// Backpressure: when full and out_ready=0 the output holds, all in_ready stay 0 and the scan pointer freezes.
// Ports: clk, rst_n (async, active-low), bus (scan_mux_reg_if.slave).
// Build option: define MUX_SCAN_EN to enable scan mode; otherwise mode is ignored (direct only).
module scan_mux_reg
  import mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  scan_mux_reg_if.slave bus
);

  localparam int SEL_W = $clog2(CHANNELS);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] sel_q;
  logic             err_q;

  logic             can_capture;
  logic             addr_ok;
  logic             scan_sel;
  logic             sel_vld;
  logic             capture;
  logic             addr_err_d;
  logic [SEL_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_data;
  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;

  assign can_capture = (state_q == ST_EMPTY) | bus.out_ready;
  // Only false when CHANNELS is not a power of two.
  assign addr_ok     = int'(bus.address) < CHANNELS;

`ifdef MUX_SCAN_EN
  logic [SEL_W-1:0] ptr_q;

  rr_pick #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr_pick (
    .valid (bus.in_valid),
    .ptr   (ptr_q),
    .found (rr_found),
    .idx   (rr_idx)
  );

  assign scan_sel = (bus.mode == MODE_SCAN);

  // The pointer only moves on a scan-mode capture, so it survives any
  // stretch of direct-mode traffic untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (capture && scan_sel) begin
      ptr_q <= (rr_idx == SEL_W'(CHANNELS - 1)) ? '0 : rr_idx + 1'b1;
    end
  end
`else
  wire unused_mode = bus.mode;

  assign scan_sel = 1'b0;
  assign rr_found = 1'b0;
  assign rr_idx   = '0;
`endif

  always_comb begin
    sel_idx = bus.address;
    sel_vld = addr_ok && bus.in_valid[bus.address];
    if (scan_sel) begin
      sel_idx = rr_idx;
      sel_vld = rr_found;
    end
  end

  // Gated by rst_n so no producer sees a handshake while reset is held.
  assign capture    = rst_n & can_capture & sel_vld;
  assign addr_err_d = !scan_sel && !addr_ok && can_capture;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_idx == SEL_W'(k)) sel_data = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    bus.in_ready = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      bus.in_ready[k] = capture && (sel_idx == SEL_W'(k));
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (capture)                      state_d = ST_FULL;
      ST_FULL:  if (bus.out_ready && !capture)    state_d = ST_EMPTY;
      default:                                    state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= addr_err_d;
      if (capture) begin
        data_q <= sel_data;
        sel_q  <= sel_idx;
      end
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.addr_err  = err_q;

endmodule

// File: tb/tb_scan_mux_reg.sv
// Bench for scan_mux_reg: a 4-channel and a 3-channel instance share one stimulus stream.
// Latency: checks registered outputs one cycle after capture, in_ready in the same cycle.
// Backpressure: exercised via out_ready held low in vectors and random traffic.
module tb_scan_mux_reg;

`ifdef MUX_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  typedef struct {
    bit         v;
    logic [7:0] d;
    int         sel;
    int         ptr;
    bit         err;
  } mstate_t;

  typedef struct {
    bit          mode;
    int          addr;
    logic [3:0]  vld;
    logic [31:0] dat;
    bit          ordy;
    logic [3:0]  rdy;
    bit          v;
    logic [7:0]  d;
    int          sel;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  mstate_t m4, m3;

  bit          cur_mode;
  int          cur_addr;
  logic [3:0]  cur_vld;
  logic [31:0] cur_dat;
  bit          cur_ordy;

  scan_mux_reg_if #(.WIDTH(8), .CHANNELS(4)) b4 ();
  scan_mux_reg_if #(.WIDTH(8), .CHANNELS(3)) b3 ();

  scan_mux_reg #(.WIDTH(8), .CHANNELS(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  scan_mux_reg #(.WIDTH(8), .CHANNELS(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  function automatic mstate_t reset_state();
    mstate_t s;
    s.v = 1'b0; s.d = 8'h00; s.sel = 0; s.ptr = 0; s.err = 1'b0;
    return s;
  endfunction

  // Reference: one clock of the output buffer, straight from the channel rules.
  function automatic void model_step(input int ch, inout mstate_t s, output logic [3:0] exp_rdy);
    bit can;
    bit scan;
    int pick;
    can  = !s.v || cur_ordy;
    scan = SCAN_EN && cur_mode;
    pick = -1;
    if (can) begin
      if (scan) begin
        for (int k = 0; k < ch; k++) begin
          int c;
          c = (s.ptr + k) % ch;
          if (pick < 0 && cur_vld[c]) pick = c;
        end
      end else if (cur_addr < ch && cur_vld[cur_addr]) begin
        pick = cur_addr;
      end
    end
    exp_rdy = 4'b0000;
    if (pick >= 0) exp_rdy[pick] = 1'b1;
    s.err = !scan && can && (cur_addr >= ch);
    if (pick >= 0) begin
      s.v   = 1'b1;
      s.d   = cur_dat[pick*8 +: 8];
      s.sel = pick;
      if (scan) s.ptr = (pick + 1) % ch;
    end else if (cur_ordy) begin
      s.v = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit mode, input int addr, input logic [3:0] vld,
                       input logic [31:0] dat, input bit ordy);
    cur_mode = mode; cur_addr = addr; cur_vld = vld; cur_dat = dat; cur_ordy = ordy;
    b4.mode = mode; b4.address = 2'(addr); b4.in_valid = vld;      b4.in_data = dat;        b4.out_ready = ordy;
    b3.mode = mode; b3.address = 2'(addr); b3.in_valid = vld[2:0]; b3.in_data = dat[23:0];  b3.out_ready = ordy;
  endtask

  // Entered 1 time unit after a rising edge; samples at the falling edge,
  // advances the models, and returns 1 unit after the next rising edge.
  task automatic cycle(output logic [3:0] rdy4);
    logic [3:0] e4, e3;
    #4;
    if (!rst_n) begin
      m4 = reset_state();
      m3 = reset_state();
    end
    chk("u4 out_valid", b4.out_valid, m4.v);
    chk("u3 out_valid", b3.out_valid, m3.v);
    if (m4.v) begin
      chk("u4 out_data", b4.out_data, m4.d);
      chk("u4 out_sel", b4.out_sel, m4.sel);
    end
    if (m3.v) begin
      chk("u3 out_data", b3.out_data, m3.d);
      chk("u3 out_sel", b3.out_sel, m3.sel);
    end
    chk("u4 addr_err", b4.addr_err, m4.err);
    chk("u3 addr_err", b3.addr_err, m3.err);
    rdy4 = b4.in_ready;
    if (rst_n) begin
      model_step(4, m4, e4);
      model_step(3, m3, e3);
    end else begin
      e4 = 4'b0000;
      e3 = 4'b0000;
    end
    chk("u4 in_ready", b4.in_ready, e4);
    chk("u3 in_ready", {1'b0, b3.in_ready}, e3);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t       vecs[9];
    int         exp_sel[6];
    logic [3:0] r4;

    vecs[0] = '{mode:0, addr:2, vld:4'b0100, dat:32'h00A50000, ordy:1, rdy:4'b0100, v:1, d:8'hA5, sel:2};
    vecs[1] = '{mode:0, addr:2, vld:4'b0100, dat:32'h003C0000, ordy:0, rdy:4'b0000, v:1, d:8'hA5, sel:2};
    vecs[2] = '{mode:0, addr:2, vld:4'b0100, dat:32'h003C0000, ordy:0, rdy:4'b0000, v:1, d:8'hA5, sel:2};
    vecs[3] = '{mode:0, addr:2, vld:4'b0100, dat:32'h003C0000, ordy:0, rdy:4'b0000, v:1, d:8'hA5, sel:2};
    vecs[4] = '{mode:0, addr:2, vld:4'b0100, dat:32'h003C0000, ordy:1, rdy:4'b0100, v:1, d:8'h3C, sel:2};
    vecs[5] = '{mode:0, addr:2, vld:4'b0000, dat:32'h00000000, ordy:1, rdy:4'b0000, v:0, d:8'h00, sel:0};
    vecs[6] = '{mode:0, addr:1, vld:4'b0010, dat:32'h00005A00, ordy:0, rdy:4'b0010, v:1, d:8'h5A, sel:1};
    vecs[7] = '{mode:0, addr:3, vld:4'b1000, dat:32'hC3000000, ordy:1, rdy:4'b1000, v:1, d:8'hC3, sel:3};
    vecs[8] = '{mode:0, addr:0, vld:4'b1110, dat:32'h12345678, ordy:1, rdy:4'b0000, v:0, d:8'h00, sel:0};
    exp_sel = '{0, 1, 3, 0, 1, 3};

    m4 = reset_state();
    m3 = reset_state();

    // Reset held with every channel offering data.
    rst_n = 1'b0;
    drive(0, 0, 4'hF, 32'h11223344, 1);
    @(posedge clk); #1;
    cycle(r4);
    chk("reset in_ready", r4, 4'b0000);
    chk("reset out_data", b4.out_data, 8'h00);
    cycle(r4);
    rst_n = 1'b1;

    // Fill the buffer, then drop reset mid-cycle with no clock edge.
    drive(0, 0, 4'hF, 32'h11223344, 0);
    cycle(r4);
    chk("full before async reset", b4.out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset u4 out_valid", b4.out_valid, 1'b0);
    chk("async reset u3 out_valid", b3.out_valid, 1'b0);
    chk("async reset out_data", b4.out_data, 8'h00);
    m4 = reset_state();
    m3 = reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Direct capture, backpressure hold, release, drain.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].mode, vecs[i].addr, vecs[i].vld, vecs[i].dat, vecs[i].ordy);
      cycle(r4);
      chk($sformatf("vec%0d in_ready", i), r4, vecs[i].rdy);
      chk($sformatf("vec%0d out_valid", i), b4.out_valid, vecs[i].v);
      if (vecs[i].v) begin
        chk($sformatf("vec%0d out_data", i), b4.out_data, vecs[i].d);
        chk($sformatf("vec%0d out_sel", i), b4.out_sel, vecs[i].sel);
      end
    end

`ifdef MUX_SCAN_EN
    // Round-robin over channels 0,1,3 with the pointer starting at 0.
    drive(1, 0, 4'b1011, 32'h04030201, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(r4);
      chk($sformatf("scan%0d out_sel", i), b4.out_sel, exp_sel[i]);
      chk($sformatf("scan%0d out_data", i), b4.out_data, exp_sel[i] + 1);
    end

    // Move the pointer to 2, then only channel 1 is offering.
    drive(1, 0, 4'b0010, 32'h04030201, 1);
    cycle(r4);
    cycle(r4);
    chk("sparse in_ready", r4, 4'b0010);
    chk("sparse out_sel", b4.out_sel, 1);
    drive(1, 0, 4'b0000, 32'h04030201, 1);
    cycle(r4);
    chk("sparse drain out_valid", b4.out_valid, 1'b0);
    // A direct-mode capture must not disturb the pointer.
    drive(0, 0, 4'b0001, 32'h04030201, 1);
    cycle(r4);
    drive(1, 0, 4'b1111, 32'h04030201, 1);
    cycle(r4);
    chk("pointer kept in_ready", r4, 4'b0100);
    chk("pointer kept out_sel", b4.out_sel, 2);
`endif

    // Out-of-range direct address on the 3-channel instance.
    drive(0, 0, 4'b0000, 32'h0, 1);
    cycle(r4);
    drive(0, 3, 4'b0111, 32'h00CCBBAA, 1);
    cycle(r4);
    chk("ch3 addr_err pulse", b3.addr_err, 1'b1);
    chk("ch3 no capture", b3.out_valid, 1'b0);
    drive(0, 0, 4'b0111, 32'h00CCBBAA, 0);
    cycle(r4);
    chk("ch3 addr_err clears", b3.addr_err, 1'b0);
    chk("ch3 capture after err", b3.out_data, 8'hAA);
    drive(0, 3, 4'b0111, 32'h00CCBBAA, 0);
    cycle(r4);
    chk("ch3 no err when stalled", b3.addr_err, 1'b0);

    // Random traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(1)), $urandom_range(3), 4'($urandom_range(15)),
            $urandom, $urandom_range(3) != 0);
      cycle(r4);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
